// File: rtl/conv_ancho_a_angosto_if.sv
// Handshake bundle for the wide-to-narrow converter: wide word in, narrow slice out.
interface conv_ancho_a_angosto_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 8,
   parameter int DEPTH = 4
);
   localparam int RATIO = IN_W / OUT_W;
   localparam int IDX_W = $clog2(RATIO);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [IN_W-1:0]  data_in;
   logic             valid_in;
   logic             ready_in;
   logic [OUT_W-1:0] data_out;
   logic             valid_out;
   logic             ready_out;
   logic             last_out;
   logic [IDX_W-1:0] slice_idx;
   logic [CNT_W-1:0] fifo_count;

   // Environment side: supplies wide words and accepts narrow slices.
   modport master (
      output data_in, valid_in, ready_out,
      input  ready_in, data_out, valid_out, last_out, slice_idx, fifo_count
   );

   // Converter side.
   modport slave (
      input  data_in, valid_in, ready_out,
      output ready_in, data_out, valid_out, last_out, slice_idx, fifo_count
   );
endinterface

// File: rtl/conv_ancho_a_angosto.sv
// Wide-to-narrow converter: buffers IN_W-bit words in a DEPTH-entry FIFO and
// replays each one as RATIO = IN_W/OUT_W consecutive OUT_W-bit slices.
//
// state | meaning
// IDLE  | no word in the serializer, data_out held at 0
// SHIFT | a word is in the shift register, one slice shown until accepted
module conv_ancho_a_angosto #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   conv_ancho_a_angosto_if.slave bus
);
   localparam int RATIO = IN_W / OUT_W;
   localparam int IDX_W = $clog2(RATIO);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   state_t state_q, state_d;

   logic [IN_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [IN_W-1:0]  sh_q, sh_next, head_word;
   logic [OUT_W-1:0] dout_q, head_slice, next_slice;
   logic [IDX_W-1:0] idx_q;
   logic             ready_in_w, push, fifo_nonempty, at_last, word_done, load, advance;
   logic             valid_w, last_w;

   // ready_in is gated by reset so it drops the moment reset is asserted.
   assign ready_in_w    = reset && (count_q < CNT_W'(DEPTH));
   assign push          = bus.valid_in && ready_in_w;
   assign fifo_nonempty = (count_q != '0);
   assign at_last       = (state_q == SHIFT) && (idx_q == LAST_IDX);
   assign word_done     = at_last && bus.ready_out;
   assign load          = fifo_nonempty && ((state_q == IDLE) || word_done);
   assign advance       = (state_q == SHIFT) && bus.ready_out && !at_last;

   // FIFO storage; contents need no reset since pointers and count gate every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.data_in;
   end

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (load) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, load})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: a load always lands in SHIFT, so back-to-back words never pass through IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (word_done && !load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the registered state and slice index.
   always_comb begin
      valid_w = (state_q == SHIFT);
      last_w  = at_last;
   end

   // Slice extraction: the shift register always presents the next slice at one fixed end.
   always_comb begin
      head_word = mem[rd_ptr_q];
      if (MSB_FIRST) begin
         sh_next    = sh_q << OUT_W;
         head_slice = head_word[IN_W-1 -: OUT_W];
         next_slice = sh_next[IN_W-1 -: OUT_W];
      end else begin
         sh_next    = sh_q >> OUT_W;
         head_slice = head_word[OUT_W-1:0];
         next_slice = sh_next[OUT_W-1:0];
      end
   end

   // Datapath: data_out is registered and forced to 0 whenever the serializer goes idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q   <= '0;
         idx_q  <= '0;
         dout_q <= '0;
      end else if (load) begin
         sh_q   <= head_word;
         idx_q  <= '0;
         dout_q <= head_slice;
      end else if (advance) begin
         sh_q   <= sh_next;
         idx_q  <= idx_q + IDX_W'(1);
         dout_q <= next_slice;
      end else if (word_done) begin
         idx_q  <= '0;
         dout_q <= '0;
      end
   end

   assign bus.ready_in   = ready_in_w;
   assign bus.data_out   = dout_q;
   assign bus.valid_out  = valid_w;
   assign bus.last_out   = last_w;
   assign bus.slice_idx  = idx_q;
   assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_conv_ancho_a_angosto.sv
// Bench for conv_ancho_a_angosto: an MSB-first and an LSB-first instance share
// the same stimulus; a queue-based scoreboard checks every cycle.
module tb_conv_ancho_a_angosto;
   localparam int IN_W  = 32;
   localparam int OUT_W = 8;
   localparam int DEPTH = 4;
   localparam int RATIO = IN_W / OUT_W;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv_ancho_a_angosto_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus_m ();
   conv_ancho_a_angosto_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus_l ();

   assign bus_l.data_in   = bus_m.data_in;
   assign bus_l.valid_in  = bus_m.valid_in;
   assign bus_l.ready_out = bus_m.ready_out;

   conv_ancho_a_angosto #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bus(bus_m));
   conv_ancho_a_angosto #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bus(bus_l));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Slice k of a word in emission order, straight from the slicing rule.
   function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w, input int k, input bit msb);
      int pos;
      pos = msb ? (RATIO - 1 - k) : k;
      return OUT_W'(w >> (pos * OUT_W));
   endfunction

   typedef struct {
      logic [IN_W-1:0]  word;
      logic [OUT_W-1:0] msb [RATIO];
      logic [OUT_W-1:0] lsb [RATIO];
   } vec_t;
   vec_t vecs [4];

   // Scoreboard state: expected slices per instance, words pushed and words started.
   logic [OUT_W-1:0] q_m [$];
   logic [OUT_W-1:0] q_l [$];
   int pushed = 0, pushed_lag = 0, started = 0, m_idx = 0;
   bit prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;

   task automatic model_clear();
      q_m.delete();
      q_l.delete();
      pushed = 0; pushed_lag = 0; started = 0; m_idx = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0;
   endtask

   // Cycle monitor: a word pushed by edge E-1 may be shown after edge E; shown slices never retract.
   always @(negedge clk) begin
      if (reset) begin
         bit exp_v;
         if (prev_valid && !(prev_ready && prev_last)) exp_v = 1'b1;
         else                                          exp_v = (pushed_lag - started) > 0;
         chk("mon_valid_m", 32'(bus_m.valid_out), 32'(exp_v));
         chk("mon_valid_l", 32'(bus_l.valid_out), 32'(exp_v));
         if (exp_v) begin
            if (!prev_valid || (prev_ready && prev_last)) begin
               started++;
               m_idx = 0;
            end else if (prev_ready) begin
               m_idx++;
            end
         end
         chk("mon_count", 32'(bus_m.fifo_count), pushed - started);
         chk("mon_ready_in", 32'(bus_m.ready_in), 32'((pushed - started) < DEPTH));
         if (exp_v) begin
            chk("mon_idx", 32'(bus_m.slice_idx), m_idx);
            chk("mon_last", 32'(bus_m.last_out), 32'(m_idx == RATIO - 1));
            chk("mon_idx_l", 32'(bus_l.slice_idx), m_idx);
            if (q_m.size() > 0) begin
               chk("mon_data_m", 32'(bus_m.data_out), 32'(q_m[0]));
               chk("mon_data_l", 32'(bus_l.data_out), 32'(q_l[0]));
            end else begin
               chk("mon_underflow", 32'(q_m.size()), 32'd1);
            end
            if (bus_m.ready_out && q_m.size() > 0) begin
               void'(q_m.pop_front());
               void'(q_l.pop_front());
            end
         end else begin
            chk("mon_idle_data_m", 32'(bus_m.data_out), 32'd0);
            chk("mon_idle_data_l", 32'(bus_l.data_out), 32'd0);
            chk("mon_idle_last", 32'(bus_m.last_out), 32'd0);
         end
         prev_valid = exp_v;
         prev_ready = bus_m.ready_out;
         prev_last  = (m_idx == RATIO - 1);
         pushed_lag = pushed;
         if (bus_m.valid_in && bus_m.ready_in) begin
            pushed++;
            for (int k = 0; k < RATIO; k++) begin
               q_m.push_back(slice_of(bus_m.data_in, k, 1'b1));
               q_l.push_back(slice_of(bus_m.data_in, k, 1'b0));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge with valid_in still high.
   task automatic push_word(input logic [IN_W-1:0] w);
      bit ok;
      int n;
      n = 0;
      bus_m.data_in  = w;
      bus_m.valid_in = 1'b1;
      do begin
         @(negedge clk);
         ok = bus_m.ready_in;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid_m"}, 32'(bus_m.valid_out), 32'd0);
      chk({tag, "_valid_l"}, 32'(bus_l.valid_out), 32'd0);
      chk({tag, "_data_m"},  32'(bus_m.data_out), 32'd0);
      chk({tag, "_data_l"},  32'(bus_l.data_out), 32'd0);
      chk({tag, "_last"},    32'(bus_m.last_out), 32'd0);
      chk({tag, "_idx"},     32'(bus_m.slice_idx), 32'd0);
      chk({tag, "_count"},   32'(bus_m.fifo_count), 32'd0);
      chk({tag, "_ready_in"},32'(bus_m.ready_in), 32'd0);
   endtask

   // One isolated word with ready_out high: compare every slice against the table.
   task automatic run_vector(input int i);
      bus_m.ready_out = 1'b1;
      push_word(vecs[i].word);
      bus_m.valid_in = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_latency", i), 32'(bus_m.valid_out), 32'd0);
      for (int k = 0; k < RATIO; k++) begin
         @(negedge clk);
         chk($sformatf("vec%0d_k%0d_valid", i, k),  32'(bus_m.valid_out), 32'd1);
         chk($sformatf("vec%0d_k%0d_data_m", i, k), 32'(bus_m.data_out), 32'(vecs[i].msb[k]));
         chk($sformatf("vec%0d_k%0d_data_l", i, k), 32'(bus_l.data_out), 32'(vecs[i].lsb[k]));
         chk($sformatf("vec%0d_k%0d_idx", i, k),    32'(bus_m.slice_idx), k);
         chk($sformatf("vec%0d_k%0d_last", i, k),   32'(bus_m.last_out), 32'(k == RATIO - 1));
      end
      @(negedge clk);
      chk($sformatf("vec%0d_after_valid", i), 32'(bus_m.valid_out), 32'd0);
      chk($sformatf("vec%0d_after_data", i),  32'(bus_m.data_out), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Three words back-to-back; with stall set, ready_out drops for 3 cycles while slice BB shows.
   task automatic run_three(input bit stall);
      logic [IN_W-1:0] w [3];
      w[0] = 32'hFD554488;
      w[1] = 32'hCCBBAAFF;
      w[2] = 32'hFD554488;
      bus_m.ready_out = 1'b1;
      fork
         begin
            for (int j = 0; j < 3; j++) push_word(w[j]);
            bus_m.valid_in = 1'b0;
         end
         begin
            int pos;
            int c;
            bit r;
            pos = 0;
            c   = 0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            while (pos < 3 * RATIO) begin
               if (c > 0) begin
                  @(posedge clk);
                  #1;
               end
               r = !(stall && c >= 5 && c <= 7);
               bus_m.ready_out = r;
               @(negedge clk);
               chk($sformatf("three%0d_c%0d_valid", stall, c),  32'(bus_m.valid_out), 32'd1);
               chk($sformatf("three%0d_c%0d_data_m", stall, c), 32'(bus_m.data_out),
                   32'(slice_of(w[pos / RATIO], pos % RATIO, 1'b1)));
               chk($sformatf("three%0d_c%0d_data_l", stall, c), 32'(bus_l.data_out),
                   32'(slice_of(w[pos / RATIO], pos % RATIO, 1'b0)));
               chk($sformatf("three%0d_c%0d_idx", stall, c),    32'(bus_m.slice_idx), pos % RATIO);
               chk($sformatf("three%0d_c%0d_last", stall, c),   32'(bus_m.last_out),
                   32'((pos % RATIO) == RATIO - 1));
               if (r) pos++;
               c++;
            end
         end
      join
      @(negedge clk);
      chk($sformatf("three%0d_end_valid", stall), 32'(bus_m.valid_out), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      bus_m.valid_in  = 1'b0;
      bus_m.ready_out = 1'b1;
      while ((q_m.size() != 0 || bus_m.valid_out || bus_m.fifo_count != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_queue_empty"}, 32'(q_m.size()), 32'd0);
      chk({name, "_count_zero"},  32'(bus_m.fifo_count), 32'd0);
      chk({name, "_valid_zero"},  32'(bus_m.valid_out), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Backpressure from the start: 5 words fit (4 FIFO + 1 serializer), the 6th waits.
   task automatic fill_test();
      logic [IN_W-1:0] w [6];
      for (int j = 0; j < 6; j++) w[j] = 32'h11111111 * (j + 1);
      bus_m.ready_out = 1'b0;
      for (int j = 0; j < 5; j++) push_word(w[j]);
      bus_m.data_in = w[5];
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk($sformatf("fill_hold%0d_ready_in", n), 32'(bus_m.ready_in), 32'd0);
         chk($sformatf("fill_hold%0d_count", n),    32'(bus_m.fifo_count), DEPTH);
         chk($sformatf("fill_hold%0d_valid", n),    32'(bus_m.valid_out), 32'd1);
         chk($sformatf("fill_hold%0d_data_m", n),   32'(bus_m.data_out), 32'(slice_of(w[0], 0, 1'b1)));
         chk($sformatf("fill_hold%0d_data_l", n),   32'(bus_l.data_out), 32'(slice_of(w[0], 0, 1'b0)));
         @(posedge clk);
         #1;
      end
      bus_m.ready_out = 1'b1;
      push_word(w[5]);
      drain("fill");
   endtask

   // Reset asserted between edges while slice 1 is showing and another word is queued.
   task automatic reset_mid_word();
      int n;
      bus_m.ready_out = 1'b1;
      push_word(32'hFFAABB22);
      push_word(32'h0A0B0C0D);
      bus_m.valid_in = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus_m.valid_out && bus_m.slice_idx == 2'(1)) && n < 50);
      chk("mid_reached_idx", 32'(bus_m.slice_idx), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_reset%0d_valid", k), 32'(bus_m.valid_out), 32'd0);
         chk($sformatf("post_reset%0d_count", k), 32'(bus_m.fifo_count), 32'd0);
      end
      @(posedge clk);
      #1;
      run_vector(3);
   endtask

   // Random traffic; an offered word is held until accepted, ready_out bias varies by phase.
   task automatic random_phase(input int cycles);
      bit acc;
      int rdy_pct;
      acc = 1'b0;
      bus_m.valid_in = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         rdy_pct = (c < cycles / 3) ? 30 : 75;
         if (!bus_m.valid_in || acc) begin
            bus_m.valid_in = ($urandom_range(0, 99) < 60);
            bus_m.data_in  = $urandom;
         end
         bus_m.ready_out = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         acc = bus_m.valid_in && bus_m.ready_in;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].word = 32'hFFAABB22;
      vecs[0].msb  = '{8'hFF, 8'hAA, 8'hBB, 8'h22};
      vecs[0].lsb  = '{8'h22, 8'hBB, 8'hAA, 8'hFF};
      vecs[1].word = 32'hFD554488;
      vecs[1].msb  = '{8'hFD, 8'h55, 8'h44, 8'h88};
      vecs[1].lsb  = '{8'h88, 8'h44, 8'h55, 8'hFD};
      vecs[2].word = 32'hCCBBAAFF;
      vecs[2].msb  = '{8'hCC, 8'hBB, 8'hAA, 8'hFF};
      vecs[2].lsb  = '{8'hFF, 8'hAA, 8'hBB, 8'hCC};
      vecs[3].word = 32'h12345678;
      vecs[3].msb  = '{8'h12, 8'h34, 8'h56, 8'h78};
      vecs[3].lsb  = '{8'h78, 8'h56, 8'h34, 8'h12};

      bus_m.data_in   = '0;
      bus_m.valid_in  = 1'b0;
      bus_m.ready_out = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 3; i++) run_vector(i);
      run_three(1'b0);
      run_three(1'b1);
      fill_test();
      reset_mid_word();
      random_phase(600);
      drain("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
